// File: rtl/dino_score_counter.sv
// Frame-driven BCD score engine for Dino Run: frame detect off vga_vs, IDLE/RUN/OVER FSM,
// saturating BCD score. High-score register is built only when DINO_SCORE_HISCORE_EN is defined.
module dino_score_counter #(
  parameter int DIGITS           = 4,
  parameter int FRAMES_PER_POINT = 6,
  parameter int MILESTONE_DIGIT  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vga_vs,
  input  logic                start,
  input  logic                hit,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [4*DIGITS-1:0] hi_bcd,
  output logic                frame_tick,
  output logic                score_tick,
  output logic                milestone,
  output logic [1:0]          state
);

  localparam int CW = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
  localparam logic [CW-1:0] LAST_FRAME = CW'(FRAMES_PER_POINT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_vs_q;
  logic                r_frame_tick;
  logic                r_score_tick;
  logic                r_milestone;
  logic [CW-1:0]       r_frame_cnt;
  logic [4*DIGITS-1:0] r_score;
  logic [4*DIGITS-1:0] w_score_inc;
  logic                w_all9;
  logic                w_low9;
  logic                w_carry;
  logic                w_clear;
  logic                w_advance;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (hit)   w_state_nxt = S_OVER;
      S_OVER:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // hit in RUN suppresses the frame advance of the same cycle
  always_comb begin
    w_clear   = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      S_IDLE, S_OVER: w_clear   = start;
      S_RUN:          w_advance = r_frame_tick && !hit;
      default: begin
        w_clear   = 1'b0;
        w_advance = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_score_inc = r_score;
    w_all9      = 1'b1;
    w_low9      = 1'b1;
    w_carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_score[4*i +: 4] != 4'd9) w_all9 = 1'b0;
      if ((i < MILESTONE_DIGIT) && (r_score[4*i +: 4] != 4'd9)) w_low9 = 1'b0;
      if (w_carry) begin
        if (r_score[4*i +: 4] == 4'd9) begin
          w_score_inc[4*i +: 4] = 4'd0;
        end else begin
          w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
          w_carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vs_q       <= 1'b1;
      r_frame_tick <= 1'b0;
      r_score_tick <= 1'b0;
      r_milestone  <= 1'b0;
      r_frame_cnt  <= '0;
      r_score      <= '0;
    end else begin
      r_vs_q       <= vga_vs;
      r_frame_tick <= r_vs_q & ~vga_vs;
      r_score_tick <= 1'b0;
      r_milestone  <= 1'b0;
      if (w_clear) begin
        r_score     <= '0;
        r_frame_cnt <= '0;
      end else if (w_advance) begin
        if (r_frame_cnt == LAST_FRAME) begin
          r_frame_cnt <= '0;
          if (!w_all9) begin
            r_score      <= w_score_inc;
            r_score_tick <= 1'b1;
            r_milestone  <= w_low9;
          end
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

`ifdef DINO_SCORE_HISCORE_EN
  logic                r_cmp_pend;
  logic [4*DIGITS-1:0] r_hi;
  logic                w_score_gt;
  logic                w_decided;

  // digit-wise magnitude compare, most significant digit decides first
  always_comb begin
    w_score_gt = 1'b0;
    w_decided  = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!w_decided && (r_score[4*i +: 4] != r_hi[4*i +: 4])) begin
        w_score_gt = (r_score[4*i +: 4] > r_hi[4*i +: 4]);
        w_decided  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmp_pend <= 1'b0;
      r_hi       <= '0;
    end else begin
      r_cmp_pend <= (r_state == S_RUN) && hit;
      if (r_cmp_pend && w_score_gt) r_hi <= r_score;
    end
  end

  assign hi_bcd = r_hi;
`else
  assign hi_bcd = '0;
`endif

  assign score_bcd  = r_score;
  assign frame_tick = r_frame_tick;
  assign score_tick = r_score_tick;
  assign milestone  = r_milestone;
  assign state      = r_state;

endmodule

// File: doc/dino_score_counter.md
# dino_score_counter

Game-side score engine for the Dino Run display. It counts video frames off the VGA vertical sync and advances a BCD running score while the game is in play. It freezes the score on collision and holds a high score. Its outputs are the per-digit BCD values and event pulses that the HPS writes into the sprite/overlay display block, or that feed that block's score registers directly.

## Interface
Parameters:
- DIGITS, 4: number of BCD digits in score and high score (1..6).
- FRAMES_PER_POINT, 6: frame ticks per score increment (1..255).
- MILESTONE_DIGIT, 2: digit index whose rollover fires `milestone`. Value 2 means every 100 points.

Ports:
- clk  in  1  system clock, 50 MHz, same clock as the VGA counters.
- reset  in  1  asynchronous, active-low; block is in reset while `reset`==0.
- vga_vs  in  1  active-low vertical sync from the VGA timing counters, synchronous to clk.
- start  in  1  one-cycle pulse: begin a new run.
- hit  in  1  one-cycle pulse: collision, ends the run.
- score_bcd  out  4*DIGITS  running score, digit 0 in bits [3:0].
- hi_bcd  out  4*DIGITS  high score.
- frame_tick  out  1  one-cycle pulse per frame.
- score_tick  out  1  one-cycle pulse when score increments.
- milestone  out  1  one-cycle pulse on MILESTONE_DIGIT rollover.
- state  out  2  0=IDLE, 1=RUN, 2=OVER.

## Operation
- Frame detect: `vs_q` registers `vga_vs`. A falling edge (`vs_q`=1, `vga_vs`=0) registers `frame_tick`=1 on the next edge, giving exactly one pulse per frame.
- FSM transitions:
  - IDLE --start--> RUN.
  - RUN --hit--> OVER.
  - OVER --start--> RUN.
  - `start` in RUN and `hit` outside RUN are ignored.
- Entering RUN from IDLE or OVER, on the cycle `start` is sampled: `score_bcd` cleared to 0, `frame_cnt` cleared to 0.
- In RUN, each `frame_tick`:
  - If `frame_cnt`==FRAMES_PER_POINT-1: `frame_cnt`<=0, score increments by 1 BCD, `score_tick`=1.
  - Otherwise `frame_cnt`++.
- BCD increment:
  - Digit 0 +1; a digit at 9 wraps to 0 and carries into the next digit.
  - Digits never hold values >9.
  - At all-9s the score saturates: no increment, no `score_tick`, no `milestone`.
- `milestone`=1 in the same cycle as `score_tick` when digits [MILESTONE_DIGIT-1:0] roll from all-9 to all-0.
- `hit` in RUN:
  - Score frozen.
  - Any increment pending in the same cycle is dropped; `hit` wins over `frame_tick`.
  - Moves to OVER.
  - High-score update: see Configuration.
- `frame_tick` keeps pulsing in every state. `score_tick` and `milestone` pulse only in RUN.

## Timing
- Reset values: `score_bcd`=0, `hi_bcd`=0, `frame_tick`=0, `score_tick`=0, `milestone`=0, `state`=IDLE. Internally `vs_q`=1 and `frame_cnt`=0.
- `vga_vs` fall at edge N gives `frame_tick`=1 at edge N+1.
- The score update and `score_tick` register at edge N+2, when that tick completes a point.
- All outputs are registered; none are combinational from inputs.
- `start` at edge S: `state`=RUN and score 0 visible after edge S. A `frame_tick` in the same cycle as `start` is not counted.
- `hit` at edge H: `state`=OVER after edge H. `hi_bcd` is updated after edge H+1 (one-cycle compare stage).
- Reset asserted mid-run: all state returns to reset values immediately, including `hi_bcd`. After release, behaviour is identical to power-on.

## Configuration
- Macro: `DINO_SCORE_HISCORE_EN`.
- Defined:
  - One cycle after the RUN->OVER transition, if `score_bcd` > `hi_bcd`, then `hi_bcd` <= `score_bcd`.
  - The comparison is a digit-wise BCD magnitude compare, MSD first.
- Undefined:
  - No high-score register or comparator.
  - `hi_bcd` is tied to 0 at all times.

## Test plan
- Reset, then release with no `start`, 10 frames: `state`=0, `score_bcd`=0x0000, `frame_tick` pulses 10 times, `score_tick` never pulses.
- `start`, then 60 frames with FRAMES_PER_POINT=6: `score_bcd`=0x0010, 10 `score_tick` pulses each 1 cycle after their `frame_tick`.
- Preload to 0x0099 through a run of 594 frames, then 6 more frames: score 0x0100, `milestone`=1 for exactly one cycle. Digit 0 wraps 9->0 with no non-BCD values.
- Saturation with DIGITS=2: run to 0x99, then 12 more frames: score stays 0x99, no `score_tick`, no `milestone`.
- `hit` coincident with a completing `frame_tick` at score 0x0042: score 0x0042 held, `state`=2. With `DINO_SCORE_HISCORE_EN`, `hi_bcd`=0x0042 one cycle later. Then `start` and a run to 0x0030 followed by `hit`: `hi_bcd` stays 0x0042.
- Assert `reset` (0) mid-RUN at score 0x0015: all outputs zero and `state`=0 immediately, asynchronously. After release, `start` restarts counting from 0x0000.
